// File: rtl/fpu_req_arbiter_if.sv
// fpu_req_arbiter_if -- request, FPU and response channels of the FPU sharing arbiter (rev 1.0)
`default_nettype none

interface fpu_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ-1:0]        i_req_add_sub;
  logic [NUM_REQ*DATA_W-1:0] i_req_a;
  logic [NUM_REQ*DATA_W-1:0] i_req_b;
  logic [NUM_REQ-1:0]        o_req_ready;

  logic                      o_fpu_add_sub;
  logic [DATA_W-1:0]         o_fpu_a;
  logic [DATA_W-1:0]         o_fpu_b;
  logic [DATA_W-1:0]         i_fpu_s;
  logic                      i_fpu_ov_flag;
  logic                      i_fpu_un_flag;

  logic                      o_rsp_valid;
  logic                      i_rsp_ready;
  logic [ID_W-1:0]           o_rsp_id;
  logic [DATA_W-1:0]         o_rsp_s;
  logic                      o_rsp_ov;
  logic                      o_rsp_un;

  modport master (
    input  i_req_valid, i_req_add_sub, i_req_a, i_req_b,
    output o_req_ready,
    output o_fpu_add_sub, o_fpu_a, o_fpu_b,
    input  i_fpu_s, i_fpu_ov_flag, i_fpu_un_flag,
    output o_rsp_valid, o_rsp_id, o_rsp_s, o_rsp_ov, o_rsp_un,
    input  i_rsp_ready
  );

  modport slave (
    output i_req_valid, i_req_add_sub, i_req_a, i_req_b,
    input  o_req_ready,
    input  o_fpu_add_sub, o_fpu_a, o_fpu_b,
    output i_fpu_s, i_fpu_ov_flag, i_fpu_un_flag,
    input  o_rsp_valid, o_rsp_id, o_rsp_s, o_rsp_ov, o_rsp_un,
    output i_rsp_ready
  );
endinterface

`default_nettype wire

// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter -- round-robin arbiter sharing one FPU add/sub unit among NUM_REQ requesters (rev 1.0)
`default_nettype none

module fpu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int FPU_LAT = 1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  fpu_req_arbiter_if.master bus
);

  localparam int CNT_W = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   s_q, s_d;
  logic                ov_q, ov_d;
  logic                un_q, un_d;
  logic                rsp_valid_q, rsp_valid_d;

  logic                found;
  logic [ID_W-1:0]     grant;
  logic [NUM_REQ-1:0]  ready;

  // First valid requester strictly after the last grant, wrapping around.
  always_comb begin : p_search
    int idx;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && bus.i_req_valid[idx]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  always_comb begin : p_next
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    ov_d        = ov_q;
    un_d        = un_q;
    rsp_valid_d = rsp_valid_q;
    ready       = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          ready[grant] = 1'b1;
          op_d         = bus.i_req_add_sub[grant];
          a_d          = bus.i_req_a[int'(grant)*DATA_W +: DATA_W];
          b_d          = bus.i_req_b[int'(grant)*DATA_W +: DATA_W];
          id_d         = grant;
          last_d       = grant;
          cnt_d        = CNT_W'(FPU_LAT - 1);
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          s_d         = bus.i_fpu_s;
          ov_d        = bus.i_fpu_ov_flag;
          un_d        = bus.i_fpu_un_flag;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      last_q      <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      cnt_q       <= '0;
      op_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      ov_q        <= 1'b0;
      un_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      ov_q        <= ov_d;
      un_q        <= un_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Ready is combinational from valid, so it is masked while reset is held.
  assign bus.o_req_ready   = ready & {NUM_REQ{i_rst_n}};
  assign bus.o_fpu_add_sub = op_q;
  assign bus.o_fpu_a       = a_q;
  assign bus.o_fpu_b       = b_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_id      = id_q;
  assign bus.o_rsp_s       = s_q;
  assign bus.o_rsp_ov      = ov_q;
  assign bus.o_rsp_un      = un_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_req_arbiter.sv
// tb_fpu_req_arbiter -- directed and randomized bench for fpu_req_arbiter with a transaction-level model (rev 1.0)
`default_nettype none

module tb_fpu_req_arbiter;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int LAT = 1;
  localparam int IW  = $clog2(N);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_req_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) bus ();

  fpu_req_arbiter #(.NUM_REQ(N), .DATA_W(DW), .FPU_LAT(LAT), .ID_W(IW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // Single-cycle FPU stand-in: exact IEEE results for the named vectors, a scrambled but deterministic result otherwise.
  function automatic logic [DW+1:0] fpu_fn(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] s;
    logic          ov, un;
    if (!op && a == 32'h3F800000 && b == 32'h40000000)      s = 32'h40400000;
    else if (op && a == 32'h40400000 && b == 32'h3F800000)  s = 32'h40000000;
    else if (!op && a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) s = 32'h7F800000;
    else if (op && a == 32'h00800001 && b == 32'h00800000)  s = 32'h00000001;
    else s = op ? (a - {b[15:0], b[31:16]}) : (a + {b[15:0], b[31:16]});
    ov = (s[30:23] == 8'hFF) || (s[3:0] == 4'hF);
    un = (s[30:23] == 8'h00 && s != '0) || (s[3:0] == 4'h5);
    return {ov, un, s};
  endfunction

  logic [DW+1:0] fres;
  assign fres              = fpu_fn(bus.o_fpu_add_sub, bus.o_fpu_a, bus.o_fpu_b);
  assign bus.i_fpu_s       = fres[DW-1:0];
  assign bus.i_fpu_un_flag = fres[DW];
  assign bus.i_fpu_ov_flag = fres[DW+1];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester-side stimulus
  logic [N-1:0]  rv  = '0;
  logic [N-1:0]  rop = '0;
  logic [DW-1:0] ra [N];
  logic [DW-1:0] rb [N];
  logic          rsp_rdy = 1'b1;
  int            mode    = 0;   // 0 directed, 1 keep everyone valid, 2 random

  // Transaction-level model: who may be granted, and what response is owed
  int            m_last = N - 1;
  bit            m_busy = 1'b0;
  bit            m_pend = 1'b0;
  int            m_cnt  = 0;
  int            m_id   = 0;
  logic [DW+1:0] m_res  = '0;
  int            cyc    = 0;

  // Observed DUT events
  int            olog [$];
  int            ocyc [$];
  int            hs_cyc = 0;
  logic [IW-1:0] obs_id;
  logic [DW-1:0] obs_s;
  logic          obs_ov, obs_un;

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic new_req(input int k);
    rv[k]  = 1'b1;
    rop[k] = 1'($urandom);
    ra[k]  = $urandom;
    rb[k]  = $urandom;
  endtask

  task automatic set_req(input int k, input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    rv[k]  = 1'b1;
    rop[k] = op;
    ra[k]  = a;
    rb[k]  = b;
  endtask

  task automatic drive();
    bus.i_req_valid   = rv;
    bus.i_req_add_sub = rop;
    for (int k = 0; k < N; k++) begin
      bus.i_req_a[k*DW +: DW] = ra[k];
      bus.i_req_b[k*DW +: DW] = rb[k];
    end
    bus.i_rsp_ready = rsp_rdy;
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model across the edge.
  task automatic step();
    int           g;
    logic [N-1:0] er;
    drive();
    #1;
    g  = m_busy ? -1 : rr_pick(rv, m_last);
    er = (g < 0) ? '0 : (N'(1) << g);
    check("req_ready", 64'(bus.o_req_ready), 64'(er));
    check("rsp_valid", 64'(bus.o_rsp_valid), 64'(m_pend));
    if (m_pend) begin
      check("rsp_id", 64'(bus.o_rsp_id), 64'(m_id));
      check("rsp_s",  64'(bus.o_rsp_s),  64'(m_res[DW-1:0]));
      check("rsp_un", 64'(bus.o_rsp_un), 64'(m_res[DW]));
      check("rsp_ov", 64'(bus.o_rsp_ov), 64'(m_res[DW+1]));
    end
    for (int k = 0; k < N; k++) begin
      if (bus.o_req_ready[k] === 1'b1) begin
        olog.push_back(k);
        ocyc.push_back(cyc);
      end
    end
    if (bus.o_rsp_valid === 1'b1 && rsp_rdy) begin
      obs_id = bus.o_rsp_id;
      obs_s  = bus.o_rsp_s;
      obs_ov = bus.o_rsp_ov;
      obs_un = bus.o_rsp_un;
      hs_cyc = cyc;
    end
    if (g >= 0) begin
      m_busy = 1'b1;
      m_cnt  = LAT;
      m_last = g;
      m_id   = g;
      m_res  = fpu_fn(rop[g], ra[g], rb[g]);
      rv[g]  = 1'b0;
    end else if (m_busy && !m_pend) begin
      m_cnt--;
      if (m_cnt == 0) m_pend = 1'b1;
    end else if (m_pend && rsp_rdy) begin
      m_pend = 1'b0;
      m_busy = 1'b0;
    end
    if (mode == 1 && g >= 0) new_req(g);
    if (mode == 2) begin
      for (int k = 0; k < N; k++) begin
        if (!rv[k] && ($urandom % 4) == 0) new_req(k);
        else if (rv[k] && ($urandom % 20) == 0) rv[k] = 1'b0;
      end
      rsp_rdy = (($urandom % 3) != 0);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_busy || rv != '0) && n < budget) begin
      step();
      n++;
    end
    if (m_busy || rv != '0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout observed=busy required=idle after %0d cycles", budget);
    end
  endtask

  // Entered and left on a negedge; reset is asserted mid-cycle, away from the active edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    drive();
    #1;
    check("rst_req_ready", 64'(bus.o_req_ready),   64'(0));
    check("rst_rsp_valid", 64'(bus.o_rsp_valid),   64'(0));
    check("rst_fpu_op",    64'(bus.o_fpu_add_sub), 64'(0));
    check("rst_fpu_a",     64'(bus.o_fpu_a),       64'(0));
    check("rst_fpu_b",     64'(bus.o_fpu_b),       64'(0));
    check("rst_rsp_id",    64'(bus.o_rsp_id),      64'(0));
    check("rst_rsp_s",     64'(bus.o_rsp_s),       64'(0));
    check("rst_rsp_ovun",  64'({bus.o_rsp_ov, bus.o_rsp_un}), 64'(0));
    rv     = '0;
    drive();
    m_busy = 1'b0;
    m_pend = 1'b0;
    m_last = N - 1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    for (int k = 0; k < N; k++) begin
      ra[k] = '0;
      rb[k] = '0;
    end
    rv = '1;
    drive();
    @(negedge clk);
    do_reset();

    // Single add on requester 1
    set_req(1, 1'b0, 32'h3F800000, 32'h40000000);
    drain(20);
    check("single_id",   64'(obs_id), 64'(1));
    check("single_s",    64'(obs_s),  64'h40400000);
    check("single_ovun", 64'({obs_ov, obs_un}), 64'(0));
    check("single_lat",  64'(hs_cyc - ocyc[$]), 64'(LAT + 1));

    // Subtract on requester 0
    set_req(0, 1'b1, 32'h40400000, 32'h3F800000);
    drain(20);
    check("sub_id", 64'(obs_id), 64'(0));
    check("sub_s",  64'(obs_s),  64'h40000000);

    // All requesters continuously valid from a fresh pointer
    do_reset();
    mode = 1;
    base = olog.size();
    for (int k = 0; k < N; k++) new_req(k);
    n = 0;
    while (olog.size() < base + 5 && n < 60) begin
      step();
      n++;
    end
    mode = 0;
    rv   = '0;
    drain(20);
    check("rr_count", 64'(olog.size() - base), 64'(5));
    for (int i = 0; i < 5 && base + i < olog.size(); i++) begin
      check("rr_order", 64'(olog[base+i]), 64'(exp_order[i]));
      if (i > 0) check("rr_spacing", 64'(ocyc[base+i] - ocyc[base+i-1]), 64'(LAT + 2));
    end

    // Backpressure: response held for 5 cycles while another requester waits
    new_req(3);
    rsp_rdy = 1'b0;
    n = 0;
    while (!m_pend && n < 20) begin
      step();
      n++;
    end
    new_req(0);
    base = olog.size();
    repeat (5) step();
    check("bp_no_grant", 64'(olog.size() - base), 64'(0));
    rsp_rdy = 1'b1;
    step();
    step();
    check("bp_id",  64'(obs_id), 64'(3));
    check("bp_gap", 64'(ocyc[$] - hs_cyc), 64'(1));
    check("bp_next_grant", 64'(olog[$]), 64'(0));
    drain(20);

    // Overflow and underflow flags pass straight through
    set_req(2, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF);
    drain(20);
    check("ovf_s",    64'(obs_s), 64'h7F800000);
    check("ovf_flag", 64'({obs_ov, obs_un}), 64'(2));
    set_req(1, 1'b1, 32'h00800001, 32'h00800000);
    drain(20);
    check("unf_s",    64'(obs_s), 64'h00000001);
    check("unf_flag", 64'({obs_ov, obs_un}), 64'(1));

    // Reset while a job is in EXEC, with a requester still asserting valid
    set_req(1, 1'b0, 32'h3F800000, 32'h40000000);
    step();
    rv[0] = 1'b1;
    do_reset();
    set_req(2, 1'b0, $urandom, $urandom);
    set_req(3, 1'b1, $urandom, $urandom);
    base = olog.size();
    step();
    check("rst_grant_seen", 64'(olog.size() - base), 64'(1));
    check("rst_first_grant", 64'(olog[$]), 64'(2));
    drain(30);

    // Randomized traffic with random backpressure and dropped requests
    mode = 2;
    repeat (400) step();
    mode    = 0;
    rsp_rdy = 1'b1;
    rv      = '0;
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
